ro_puf_sequencer: RTL and testbench
===================================

// Module: ro_puf_sequencer
// PURPOSE
//  Measurement controller for the 16-ring-oscillator PUF array. It steps through NUM_BITS challenge pairs.
//  For each pair it drives the mux selects, clears and gates the two RO edge counters, and samples the comparator bit.
//  Each sampled bit is packed into a response word. It replaces manual VIO driving of select1/select2/enable/reset.
//  It consumes puf_out from the counter/comparator stage.
// PARAMETERS
//  NUM_BITS       16    challenge pairs per run = response width (1..16)
//  STRIDE         1     select2 = (select1 + STRIDE) mod 16; must be 1..15
//  CLR_CYCLES     4     ctr_reset pulse length per bit (>=1)
//  WINDOW         2048  ro_enable high time per bit, clock cycles (>=1); sized so RO counts stay below 12-bit wrap
//  SETTLE_CYCLES  4     idle time after ro_enable drops, before sampling (>=3, covers synchronizer)
// PORTS
//  clock           in   1         system clock
//  reset           in   1         asynchronous, active-low reset
//  start           in   1         begin a run; sampled only in IDLE
//  abort           in   1         synchronous abandon of the current run
//  puf_out         in   1         comparator bit (counter1 > counter2), RO-clock derived, asynchronous
//  select1         out  4         mux1 select
//  select2         out  4         mux2 select
//  ro_enable       out  1         RO / counter enable
//  ctr_reset       out  1         active-high clear to both RO counters
//  busy            out  1         high in every state except IDLE
//  done            out  1         one-cycle pulse when a run completes
//  response_valid  out  1         response holds a complete result
//  response        out  NUM_BITS  bit k = puf_out result of pair k
// BEHAVIOUR
//  Reset values: all outputs 0. State = IDLE. Bit index k = 0.
//  puf_out passes through a 2-flop synchronizer. Only the synchronized value puf_s is used.
//  Pair k: select1 = k[3:0]; select2 = (k[3:0] + STRIDE) mod 16 (4-bit add, carry dropped).
//  select1/select2 are stable from CLEAR entry through SAMPLE of the same bit.
//  FSM states: IDLE, CLEAR, RUN, SETTLE, SAMPLE, DONE.
//   IDLE:   start=1 & abort=0 -> CLEAR with k=0. This clears response_valid and response.
//   CLEAR:  ctr_reset=1 for exactly CLR_CYCLES cycles, ro_enable=0 -> RUN.
//   RUN:    ro_enable=1 for exactly WINDOW cycles -> SETTLE.
//   SETTLE: ro_enable=0, ctr_reset=0 for SETTLE_CYCLES cycles -> SAMPLE.
//   SAMPLE: 1 cycle; response[k] <= puf_s. If k==NUM_BITS-1 -> DONE, else k<=k+1 -> CLEAR.
//   DONE:   1 cycle; done=1 and response_valid<=1 -> IDLE.
//  Per-bit latency: CLR_CYCLES+WINDOW+SETTLE_CYCLES+1 cycles.
//  Start-to-done latency: 1 + NUM_BITS*(per-bit latency) cycles (done asserted in the final cycle).
//  Cycle counter: one down-counter, width $clog2(max(CLR_CYCLES,WINDOW,SETTLE_CYCLES)+1). It is reloaded on every state entry.
//  start while busy: ignored. No queuing.
//  abort in any non-IDLE state -> IDLE next cycle. Same cycle: ro_enable=0, ctr_reset=0, response_valid stays 0, no done pulse.
//  start and abort together in IDLE: abort wins, remain IDLE.
//  Equal counts give puf_out=0. Bit recorded as 0, no tie flag.
//  reset asserted mid-run: immediate return to reset values. Partial response discarded.
//  response and response_valid hold after DONE until the next accepted start.
// STRUCTURE
//  Shared package ro_puf_pkg: FSM state enum, RO_COUNT=16, SEL_W=4, CTR_W=12.
//  Sub-module bit_sync2: 2-flop synchronizer (clock, reset, d, q). One instance for puf_out.
//  Remainder (FSM, cycle counter, k index, response register) is flat in this module.
// TESTING (bench: NUM_BITS=4, STRIDE=1, CLR_CYCLES=2, WINDOW=8, SETTLE_CYCLES=3; per bit = 14 cycles)
//  Reset with start=1 held -> all outputs 0, stays IDLE while reset low. Starts on the first clock after release.
//  start pulse, puf_out tied 1 -> selects (0,1),(1,2),(2,3),(3,4). done at cycle 57 after start. response=4'b1111, response_valid=1.
//  Drive puf_out = 1 only during pairs 1 and 3 -> response=4'b1010.
//  Check ro_enable is high exactly 8 cycles per bit, ctr_reset exactly 2, and never both high together.
//  abort in RUN of bit 2 -> IDLE next cycle, ro_enable=0, no done, response_valid=0. A new start then runs fully.
//  start pulses during busy -> ignored. STRIDE=15 run -> select2 = 15,0,1,2 for k=0..3.
//  Reset low during SETTLE of bit 1 -> outputs 0 asynchronously. Next run response is independent of the aborted run.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF measurement path.
// Holds the sequencer state encoding and array geometry.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam int RO_COUNT = 16;
  localparam int SEL_W    = 4;
  localparam int CTR_W    = 12;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer bringing an asynchronous level
// into the clock domain.
module bit_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ro_puf_sequencer.sv
// Steps the RO PUF array through challenge pairs and
// packs the sampled comparator bits into a response word.
module ro_puf_sequencer
  import ro_puf_pkg::*;
#(
  parameter int NUM_BITS      = 16,
  parameter int STRIDE        = 1,
  parameter int CLR_CYCLES    = 4,
  parameter int WINDOW        = 2048,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                puf_out,
  output logic [SEL_W-1:0]    select1,
  output logic [SEL_W-1:0]    select2,
  output logic                ro_enable,
  output logic                ctr_reset,
  output logic                busy,
  output logic                done,
  output logic                response_valid,
  output logic [NUM_BITS-1:0] response
);

  localparam int CW =
    $clog2(max3(CLR_CYCLES, WINDOW, SETTLE_CYCLES) + 1);
  localparam logic [CW-1:0] LD_CLR = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] LD_WIN = CW'(WINDOW - 1);
  localparam logic [CW-1:0] LD_SET = CW'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] K_LAST = SEL_W'(NUM_BITS - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]    k_q, k_nxt, sel2_q;
  logic [NUM_BITS-1:0] resp_q;
  logic                valid_q;
  logic                puf_s;
  logic                accept, sample, finish, last;

  bit_sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (puf_out),
    .q     (puf_s)
  );

  assign last   = (k_q == K_LAST);
  assign k_nxt  = k_q + SEL_W'(1);
  assign accept = (state_q == ST_IDLE) && start && !abort;
  assign sample = (state_q == ST_SAMPLE) && !abort;
  assign finish = (state_q == ST_DONE) && !abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CLEAR;
          cnt_d   = LD_CLR;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
          cnt_d   = LD_WIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = LD_SET;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SAMPLE: begin
        if (last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          state_d = ST_CLEAR;
          cnt_d   = LD_CLR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // abort overrides any in-flight transition
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      sel2_q  <= '0;
      resp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        k_q     <= '0;
        sel2_q  <= SEL_W'(STRIDE % RO_COUNT);
        resp_q  <= '0;
        valid_q <= 1'b0;
      end
      if (sample) begin
        for (int i = 0; i < NUM_BITS; i++) begin
          if (k_q == SEL_W'(i)) resp_q[i] <= puf_s;
        end
        if (!last) begin
          k_q    <= k_nxt;
          sel2_q <= SEL_W'((int'(k_nxt) + STRIDE) % RO_COUNT);
        end
      end
      if (finish) valid_q <= 1'b1;
    end
  end

  assign select1        = k_q;
  assign select2        = sel2_q;
  assign ctr_reset      = (state_q == ST_CLEAR) && !abort;
  assign ro_enable      = (state_q == ST_RUN) && !abort;
  assign busy           = (state_q != ST_IDLE);
  assign done           = finish;
  assign response_valid = valid_q;
  assign response       = resp_q;

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Scoreboard bench for ro_puf_sequencer: selects, window
// lengths, latency and response words for two strides.
module tb_ro_puf_sequencer;

  localparam int NB  = 4;
  localparam int CLR = 2;
  localparam int WIN = 8;
  localparam int SET = 3;
  localparam int LAT = 57;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       start0, abort0, start1;
  logic [1:0] pmode;
  logic       puf0;

  logic [3:0]    select1_0, select2_0, select1_1, select2_1;
  logic          ro_enable0, ctr_reset0, busy0, done0, rv0;
  logic          ro_enable1, ctr_reset1, busy1, done1, rv1;
  logic [NB-1:0] response0, response1;

  assign puf0 = (pmode == 2'd2) ? select1_0[0] : pmode[0];

  ro_puf_sequencer #(
    .NUM_BITS(NB), .STRIDE(1), .CLR_CYCLES(CLR),
    .WINDOW(WIN), .SETTLE_CYCLES(SET)
  ) u0 (
    .clock(clock), .reset(reset), .start(start0),
    .abort(abort0), .puf_out(puf0),
    .select1(select1_0), .select2(select2_0),
    .ro_enable(ro_enable0), .ctr_reset(ctr_reset0),
    .busy(busy0), .done(done0),
    .response_valid(rv0), .response(response0)
  );

  ro_puf_sequencer #(
    .NUM_BITS(NB), .STRIDE(15), .CLR_CYCLES(CLR),
    .WINDOW(WIN), .SETTLE_CYCLES(SET)
  ) u1 (
    .clock(clock), .reset(reset), .start(start1),
    .abort(1'b0), .puf_out(1'b1),
    .select1(select1_1), .select2(select2_1),
    .ro_enable(ro_enable1), .ctr_reset(ctr_reset1),
    .busy(busy1), .done(done1),
    .response_valid(rv1), .response(response1)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_sel0[$];
  logic [7:0] exp_sel1[$];
  logic [3:0] exp_resp0[$];
  logic [3:0] exp_resp1[$];

  logic [7:0] tab_s1  [4] = '{8'h01, 8'h12, 8'h23, 8'h34};
  logic [7:0] tab_s15 [4] = '{8'h0F, 8'h10, 8'h21, 8'h32};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic push_sels0(input int n);
    for (int i = 0; i < n; i++) exp_sel0.push_back(tab_s1[i]);
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (done0) seen = 1'b1;
    end
    if (!seen) timeout(nm);
    repeat (3) @(posedge clock);
    #1;
  endtask

  // monitor: pops expectations when the DUTs present them
  initial begin
    int  en_len, clr_len, bcnt0, bcnt1;
    bit  pen, pclr, pclr1, vpend;
    logic [3:0] vexp;
    logic [7:0] s;
    en_len = 0; clr_len = 0; bcnt0 = 0; bcnt1 = 0;
    pen = 0; pclr = 0; pclr1 = 0; vpend = 0; vexp = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        en_len = 0; clr_len = 0; bcnt0 = 0; bcnt1 = 0;
        pen = 0; pclr = 0; pclr1 = 0; vpend = 0;
      end else begin
        if (ro_enable0 || ctr_reset0)
          chk("en_clr_overlap", 32'(ro_enable0 & ctr_reset0), 0);
        if (ctr_reset0 && !pclr) begin
          if (exp_sel0.size() == 0) timeout("sel0_underflow");
          else begin
            s = exp_sel0.pop_front();
            chk("sel0", 32'({select1_0, select2_0}), 32'(s));
          end
          chk("rv0_low_in_run", 32'(rv0), 0);
        end
        if (ro_enable0) en_len++;
        if (ctr_reset0) clr_len++;
        if (pen && !ro_enable0) begin
          if (!abort0) chk("en_len", 32'(en_len), WIN);
          en_len = 0;
        end
        if (pclr && !ctr_reset0) begin
          if (!abort0) chk("clr_len", 32'(clr_len), CLR);
          clr_len = 0;
        end
        pen  = ro_enable0;
        pclr = ctr_reset0;
        bcnt0 = busy0 ? bcnt0 + 1 : 0;
        if (vpend) begin
          chk("rv0_after_done", 32'(rv0), 1);
          chk("resp0_hold", 32'(response0), 32'(vexp));
          vpend = 0;
        end
        if (done0) begin
          if (exp_resp0.size() == 0) timeout("resp0_underflow");
          else begin
            vexp = exp_resp0.pop_front();
            chk("resp0", 32'(response0), 32'(vexp));
            chk("lat0", 32'(bcnt0), LAT);
            vpend = 1;
          end
        end
        if (ctr_reset1 && !pclr1) begin
          if (exp_sel1.size() == 0) timeout("sel1_underflow");
          else begin
            s = exp_sel1.pop_front();
            chk("sel1", 32'({select1_1, select2_1}), 32'(s));
          end
        end
        pclr1 = ctr_reset1;
        bcnt1 = busy1 ? bcnt1 + 1 : 0;
        if (done1) begin
          if (exp_resp1.size() == 0) timeout("resp1_underflow");
          else begin
            chk("resp1", 32'(response1), 32'(exp_resp1.pop_front()));
            chk("lat1", 32'(bcnt1), LAT);
          end
        end
      end
    end
  end

  initial begin
    bit hit;
    reset = 1'b0; start0 = 1'b1; abort0 = 1'b0;
    start1 = 1'b0; pmode = 2'd1;
    // reset with start held high
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("reset_outs0", 32'({select1_0, select2_0, ro_enable0,
          ctr_reset0, busy0, done0, rv0, response0}), 0);
    end
    push_sels0(4);
    exp_resp0.push_back(4'b1111);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    @(negedge clock);
    chk("busy_after_release", 32'(busy0), 1);
    wait_done0("run_tied1");

    // pattern run with ignored start pulses while busy
    pmode = 2'd2;
    push_sels0(4);
    exp_resp0.push_back(4'b1010);
    pulse_start0();
    repeat (15) @(posedge clock);
    #1; start0 = 1'b1;
    @(posedge clock); #1; start0 = 1'b0;
    repeat (20) @(posedge clock);
    #1; start0 = 1'b1;
    @(posedge clock); #1; start0 = 1'b0;
    wait_done0("run_1010");

    // abort in RUN of bit 2
    pmode = 2'd1;
    push_sels0(3);
    pulse_start0();
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clock); #1;
      if (ro_enable0 && select1_0 == 4'd2) hit = 1'b1;
    end
    if (!hit) timeout("reach_run_bit2");
    abort0 = 1'b1;
    @(negedge clock);
    chk("abort_en", 32'(ro_enable0), 0);
    chk("abort_clr", 32'(ctr_reset0), 0);
    chk("abort_done", 32'(done0), 0);
    @(posedge clock); #1;
    abort0 = 1'b0;
    @(negedge clock);
    chk("abort_idle", 32'(busy0), 0);
    chk("abort_rv", 32'(rv0), 0);
    @(posedge clock); #1;
    push_sels0(4);
    exp_resp0.push_back(4'b1111);
    pulse_start0();
    wait_done0("run_after_abort");

    // reset during SETTLE of bit 1
    push_sels0(2);
    pulse_start0();
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clock); #1;
      if (ro_enable0 && select1_0 == 4'd1) hit = 1'b1;
    end
    if (!hit) timeout("reach_run_bit1");
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clock); #1;
      if (!ro_enable0) hit = 1'b1;
    end
    if (!hit) timeout("reach_settle_bit1");
    #2; reset = 1'b0;
    #1;
    chk("async_reset_outs", 32'({select1_0, select2_0, ro_enable0,
        ctr_reset0, busy0, done0, rv0, response0}), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    pmode = 2'd0;
    push_sels0(4);
    exp_resp0.push_back(4'b0000);
    pulse_start0();
    wait_done0("run_after_reset");

    // stride 15 instance
    for (int i = 0; i < 4; i++) exp_sel1.push_back(tab_s15[i]);
    exp_resp1.push_back(4'b1111);
    start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clock);
      if (done1) hit = 1'b1;
    end
    if (!hit) timeout("run_stride15");
    repeat (3) @(posedge clock);
    #1;
    chk("rv1_final", 32'(rv1), 1);
    chk("sel0_q_empty", 32'(exp_sel0.size()), 0);
    chk("sel1_q_empty", 32'(exp_sel1.size()), 0);
    chk("resp0_q_empty", 32'(exp_resp0.size()), 0);
    chk("resp1_q_empty", 32'(exp_resp1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
